// File: rtl/spi_mfrc522_responder.sv
// -----------------------------------------------------------------------------
// spi_mfrc522_responder
//
// SPI mode-0 slave that stands in for an MFRC522 reader IC. It oversamples the
// SPI pins on aclk, decodes the MFRC522 address/data byte framing, keeps a
// 64 x 8 register file and drives spi_miso for read bursts.
//
// Optional build macro: MFRC522_FIFO_EN
//   When defined, address 0x09 (FIFODataReg) is a 64-byte FIFO, 0x0A reads the
//   FIFO level (write bit7 = flush) and ErrorReg 0x06 bit4 flags overflow.
//   When undefined, 0x09 and 0x0A are plain storage registers.
//
// Ports:
//   aclk           system clock
//   aresetn        asynchronous active-low reset
//   spi_cs_n       chip select, active low
//   spi_sck        SPI clock (CPOL=0, CPHA=0)
//   spi_mosi       master-out data, MSB first
//   spi_miso       slave-out data, MSB first, 0 whenever not in a read burst
//   reg_wr_o       one-cycle pulse per accepted register write
//   reg_wr_addr_o  address of the last write
//   reg_wr_data_o  data of the last write
//   frame_err_o    one-cycle pulse on an address byte with bit0 set
//   xact_cnt_o     number of completed CS-low frames (wraps)
// -----------------------------------------------------------------------------
module spi_mfrc522_responder #(
  parameter logic [7:0] VERSION_VAL = 8'h92,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        spi_cs_n,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        reg_wr_o,
  output logic [5:0]  reg_wr_addr_o,
  output logic [7:0]  reg_wr_data_o,
  output logic        frame_err_o,
  output logic [15:0] xact_cnt_o
);

  localparam logic [5:0] VERSION_ADDR = 6'h37;
`ifdef MFRC522_FIFO_EN
  localparam logic [5:0] FIFO_DATA_ADDR  = 6'h09;
  localparam logic [5:0] FIFO_LEVEL_ADDR = 6'h0A;
  localparam int         ERROR_REG_IDX   = 6;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   cs_prev_reg;
  logic                   sck_prev_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // cs_n resets to the deselected level so no false edge appears
      cs_sync_reg   <= '1;
      sck_sync_reg  <= '0;
      mosi_sync_reg <= '0;
      cs_prev_reg   <= 1'b1;
      sck_prev_reg  <= 1'b0;
    end else begin
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_reg   <= cs_sync_reg[SYNC_STAGES-1];
      sck_prev_reg  <= sck_sync_reg[SYNC_STAGES-1];
    end
  end

  logic cs_s, sck_s, mosi_s;
  logic cs_rise, cs_fall, sck_rise, sck_fall;

  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_rise  = cs_s & ~cs_prev_reg;
  assign cs_fall  = ~cs_s & cs_prev_reg;
  assign sck_rise = sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s & sck_prev_reg;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [6:0]  shift_reg, shift_next;     // only 7 bits kept; bit 8 is live mosi
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [5:0]  addr_reg, addr_next;
  logic [7:0]  miso_reg, miso_next;
  logic [15:0] xact_cnt_reg, xact_cnt_next;
  logic        reg_wr_reg, reg_wr_next;
  logic [5:0]  reg_wr_addr_reg, reg_wr_addr_next;
  logic [7:0]  reg_wr_data_reg, reg_wr_data_next;
  logic        frame_err_reg, frame_err_next;

  logic [7:0]  rx_byte;
  logic [5:0]  rx_addr;
  logic [7:0]  rd_value;
  logic        reg_we;

  assign rx_byte = {shift_reg, mosi_s};
  assign rx_addr = rx_byte[6:1];

  // ---------------------------------------------------------------------------
  // Register file (VersionReg is a constant, never a stored cell)
  // ---------------------------------------------------------------------------
  logic [7:0] regs_rd [64];

`ifdef MFRC522_FIFO_EN
  logic       fifo_wr_req;
  logic       fifo_rd_req;
  logic       fifo_flush;
  logic       fifo_push;
  logic       fifo_pop;
  logic       ovfl_set;
  logic [7:0] fifo_mem [64];
  logic [5:0] fifo_wr_ptr_reg;
  logic [5:0] fifo_rd_ptr_reg;
  logic [6:0] fifo_level_reg;

  assign fifo_push = fifo_wr_req && (fifo_level_reg != 7'd64);
  assign ovfl_set  = fifo_wr_req && (fifo_level_reg == 7'd64);
  assign fifo_pop  = fifo_rd_req && (fifo_level_reg != 7'd0);

  always_ff @(posedge aclk) begin
    if (fifo_push) begin
      fifo_mem[fifo_wr_ptr_reg] <= rx_byte;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      fifo_level_reg  <= '0;
    end else if (fifo_flush) begin
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      fifo_level_reg  <= '0;
    end else begin
      // push and pop never coincide: at most one byte completes per cycle
      if (fifo_push) begin
        fifo_wr_ptr_reg <= fifo_wr_ptr_reg + 6'd1;
        fifo_level_reg  <= fifo_level_reg + 7'd1;
      end else if (fifo_pop) begin
        fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 6'd1;
        fifo_level_reg  <= fifo_level_reg - 7'd1;
      end
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_regs
      if (gi == int'(VERSION_ADDR)) begin : g_version
        assign regs_rd[gi] = VERSION_VAL;
      end else begin : g_cell
        logic [7:0] cell_reg;
        always_ff @(posedge aclk or negedge aresetn) begin
          if (!aresetn) begin
            cell_reg <= '0;
          end else begin
            if (reg_we && (addr_reg == 6'(gi))) begin
              cell_reg <= rx_byte;
            end
`ifdef MFRC522_FIFO_EN
            // BufferOvfl is owned by the FIFO logic once the FIFO is enabled
            if (gi == ERROR_REG_IDX) begin
              if (ovfl_set) begin
                cell_reg[4] <= 1'b1;
              end else if (fifo_flush) begin
                cell_reg[4] <= 1'b0;
              end
            end
`endif
          end
        end
        assign regs_rd[gi] = cell_reg;
      end
    end
  endgenerate

  // Read data for the address carried by the byte that is completing now
  always_comb begin
    rd_value = regs_rd[rx_addr];
`ifdef MFRC522_FIFO_EN
    if (rx_addr == FIFO_DATA_ADDR) begin
      rd_value = (fifo_level_reg == 7'd0) ? 8'h00 : fifo_mem[fifo_rd_ptr_reg];
    end else if (rx_addr == FIFO_LEVEL_ADDR) begin
      rd_value = {1'b0, fifo_level_reg};
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= ST_IDLE;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      addr_reg        <= '0;
      miso_reg        <= '0;
      xact_cnt_reg    <= '0;
      reg_wr_reg      <= 1'b0;
      reg_wr_addr_reg <= '0;
      reg_wr_data_reg <= '0;
      frame_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      bit_cnt_reg     <= bit_cnt_next;
      addr_reg        <= addr_next;
      miso_reg        <= miso_next;
      xact_cnt_reg    <= xact_cnt_next;
      reg_wr_reg      <= reg_wr_next;
      reg_wr_addr_reg <= reg_wr_addr_next;
      reg_wr_data_reg <= reg_wr_data_next;
      frame_err_reg   <= frame_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    bit_cnt_next     = bit_cnt_reg;
    addr_next        = addr_reg;
    miso_next        = miso_reg;
    xact_cnt_next    = xact_cnt_reg;
    reg_wr_next      = 1'b0;
    reg_wr_addr_next = reg_wr_addr_reg;
    reg_wr_data_next = reg_wr_data_reg;
    frame_err_next   = 1'b0;
    reg_we           = 1'b0;
`ifdef MFRC522_FIFO_EN
    fifo_wr_req      = 1'b0;
    fifo_rd_req      = 1'b0;
    fifo_flush       = 1'b0;
`endif

    if (cs_rise) begin
      // CS deassertion takes priority over any sck edge in the same cycle
      // and throws away a partial byte.
      state_next   = ST_IDLE;
      shift_next   = '0;
      bit_cnt_next = '0;
      miso_next    = '0;
      if (state_reg != ST_IDLE) begin
        xact_cnt_next = xact_cnt_reg + 16'd1;
      end
    end else if (cs_fall) begin
      state_next   = ST_ADDR;
      shift_next   = '0;
      bit_cnt_next = '0;
      miso_next    = '0;
    end else if (state_reg != ST_IDLE) begin
      if (sck_rise) begin
        shift_next   = rx_byte[6:0];
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          unique case (state_reg)
            ST_ADDR: begin
              if (rx_byte[0]) begin
                frame_err_next = 1'b1;
                state_next     = ST_IGNORE;
              end else begin
                addr_next = rx_addr;
                if (rx_byte[7]) begin
                  state_next = ST_RDATA;
                  miso_next  = rd_value;
`ifdef MFRC522_FIFO_EN
                  fifo_rd_req = (rx_addr == FIFO_DATA_ADDR);
`endif
                end else begin
                  state_next = ST_WDATA;
                end
              end
            end
            ST_WDATA: begin
              // burst writes keep hitting the same address
              if (addr_reg != VERSION_ADDR) begin
                reg_wr_next      = 1'b1;
                reg_wr_addr_next = addr_reg;
                reg_wr_data_next = rx_byte;
                reg_we           = 1'b1;
`ifdef MFRC522_FIFO_EN
                if (addr_reg == FIFO_DATA_ADDR) begin
                  reg_we      = 1'b0;
                  fifo_wr_req = 1'b1;
                end
                if (addr_reg == FIFO_LEVEL_ADDR && rx_byte[7]) begin
                  fifo_flush = 1'b1;
                end
`endif
              end
            end
            ST_RDATA: begin
              // each further read-address byte queues up the next value;
              // anything else (normally 8'h00) ends the burst
              if (rx_byte[7] && !rx_byte[0]) begin
                addr_next = rx_addr;
                miso_next = rd_value;
`ifdef MFRC522_FIFO_EN
                fifo_rd_req = (rx_addr == FIFO_DATA_ADDR);
`endif
              end else begin
                miso_next  = '0;
                state_next = ST_IGNORE;
              end
            end
            default: ;
          endcase
        end
      end else if (sck_fall && state_reg == ST_RDATA && bit_cnt_reg != 3'd0) begin
        // The falling edge that closes a byte must not shift: the MSB of the
        // freshly loaded value has to stay on the line for the next byte.
        miso_next = {miso_reg[6:0], 1'b0};
      end
    end
  end

  assign spi_miso      = (state_reg == ST_RDATA) & miso_reg[7];
  assign reg_wr_o      = reg_wr_reg;
  assign reg_wr_addr_o = reg_wr_addr_reg;
  assign reg_wr_data_o = reg_wr_data_reg;
  assign frame_err_o   = frame_err_reg;
  assign xact_cnt_o    = xact_cnt_reg;

endmodule

// File: doc/spi_mfrc522_responder.md
Name: spi_mfrc522_responder

Overview:
- Synthesizable SPI slave that emulates the MFRC522 register interface.
- It is the far end of the SPI bus driven by the SPI AXI controller, and lets integration benches and the FPGA bring-up close the loop without a real RC522 part.
- It oversamples spi_cs_n, spi_sck and spi_mosi on aclk, decodes MFRC522 address/data framing, holds a 64 x 8 register file and drives spi_miso.

Parameters:
- VERSION_VAL, 8'h92, constant value returned by VersionReg (address 0x37).
- SYNC_STAGES, 2, number of synchronizer flops on cs_n, sck and mosi (allowed range 2-3).

Ports:
- aclk  input  1  system clock.
- aresetn  input  1  asynchronous active-low reset.
- spi_cs_n  input  1  chip select, active low.
- spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_mosi  input  1  master-out data, MSB first.
- spi_miso  output  1  slave-out data, MSB first; forced 0 while deselected.
- reg_wr_o  output  1  one-cycle pulse on each accepted register write.
- reg_wr_addr_o  output  6  address of that write.
- reg_wr_data_o  output  8  data of that write.
- frame_err_o  output  1  one-cycle pulse on a malformed address byte.
- xact_cnt_o  output  16  count of completed CS-low frames; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: all outputs 0, register file 0, shift and bit counters cleared, FSM in IDLE. VersionReg is never stored; it is hard-wired to VERSION_VAL.
- Synchronization and edge detect:
  - cs_n, sck and mosi pass through SYNC_STAGES flops.
  - Edge detect compares the synchronized value with its previous sample.
  - SCK high and low times must each be at least SYNC_STAGES+2 aclk cycles.
- FSM states: IDLE -> ADDR on the cs_n falling edge. ADDR -> WDATA or RDATA after 8 rising sck edges. Any state -> IDLE on the cs_n rising edge.
- Bit capture: MOSI is sampled on each detected sck rising edge and shifted into an 8-bit register. A 3-bit counter flags byte completion on the 8th edge.
- Address byte format: bit7 = 1 means read, bits6:1 = addr, bit0 must be 0.
  - If bit0 = 1: pulse frame_err_o and enter IGNORE. No writes happen, MISO stays 0 until CS rises.
- Write frame (bit7 = 0): each completed data byte writes reg[addr].
  - reg_wr_o pulses 1 cycle after the completing edge.
  - Consecutive data bytes go to the same addr (MFRC522 burst semantics).
  - Writes to 0x37 are dropped and produce no pulse.
- Read frame (bit7 = 1):
  - On completion of each byte, the shifter loads reg[addr] (or VERSION_VAL at 0x37). Addr comes from the byte just received.
  - The MSB of the loaded value drives spi_miso within 1 aclk cycle of the load. Subsequent bits change on detected sck falling edges.
  - MOSI byte k+1 is interpreted as the next address byte. Its MISO value returns reg[addr_k].
  - A MOSI byte of 8'h00 ends the burst; MISO returns the last addressed data.
- spi_miso timing:
  - MISO is 0 during the first (address) byte of every frame.
  - MISO is 0 in IDLE, WDATA and IGNORE.
- CS handling:
  - CS rising mid-byte discards the partial byte: no write, bit counter cleared. xact_cnt_o still increments.
  - A CS rising edge and an sck edge in the same cycle: CS wins and the edge is ignored.
  - A CS pulse with zero sck edges still counts as a frame.
- Reset mid-frame: everything returns to reset values immediately. The frame in progress is lost; the next cs_n falling edge starts clean.

Optional Feature:
- Macro: MFRC522_FIFO_EN.
- Defined:
  - Address 0x09 (FIFODataReg) is backed by a 64-byte circular FIFO. Writes push; a full FIFO drops the byte and sets bit 4 (BufferOvfl) of ErrorReg 0x06.
  - Reads of 0x09 pop; an empty FIFO returns 8'h00 and does not underflow.
  - Reads of 0x0A (FIFOLevelReg) return {1'b0, level[6:0]}.
  - Writing 0x0A with bit7 = 1 flushes the FIFO and clears BufferOvfl.
- Undefined: 0x09 and 0x0A are plain storage registers.

Test Plan:
- Write frame MOSI {0x22, 0x10} (addr 0x11) -> single reg_wr_o pulse, addr 0x11, data 0x10. Read frame {0xA2, 0x00} then returns MISO 0x00, 0x10.
- Read frame {0xEE, 0x00} (VersionReg) -> MISO 0x00, 0x92. Then write frame {0x6E, 0x55} -> no reg_wr_o pulse, version still reads 0x92.
- Burst write {0x12, 0xAA, 0xBB, 0xCC, 0xDD} -> 4 pulses, all addr 0x09. Without the FIFO macro, 0x09 reads 0xDD. With MFRC522_FIFO_EN, 0x0A reads 0x04 and pops return AA, BB, CC, DD.
- Malformed address 0x23 -> frame_err_o pulse, no write, MISO 0 for the whole frame, xact_cnt_o increments by 1.
- CS rising after 5 bits of a data byte -> no write, and the next frame decodes correctly. Assert aresetn mid-read -> MISO 0 and the register file cleared.
- Two back-to-back reads of 0x11 and 0x12 (MOSI {0xA2, 0xA4, 0x00}) -> MISO {0x00, reg[0x11], reg[0x12]}. Run at the minimum SCK half-period of 4 aclk cycles.
